// File: rtl/jbi_mout_mondo_reply_pkg.sv
`default_nettype none
// ============================================================================
// jbi_mout_mondo_reply_pkg : shared types and constants for the mondo reply path
// Rev 1.0
// ============================================================================
package jbi_mout_mondo_reply_pkg;

   // JBI AD_INT field widths
   localparam int c_agtid_w = 5;
   localparam int c_cpuid_w = 5;

   localparam logic c_int_ack  = 1'b1;
   localparam logic c_int_nack = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ISSUE = 2'd2,
      ST_GAP   = 2'd3
   } reply_state_t;

endpackage
`default_nettype wire

// File: rtl/jbi_mout_mondo_reply_if.sv
`default_nettype none
// ============================================================================
// jbi_mout_mondo_reply_if : ack-queue, arbiter and reply payload signal bundle
// Rev 1.0
// ============================================================================
interface jbi_mout_mondo_reply_if
   import jbi_mout_mondo_reply_pkg::*;
#(
   parameter int AGTID_W = c_agtid_w,
   parameter int CPUID_W = c_cpuid_w,
   parameter int CNT_W   = 16
);
   logic               ncio_mondo_req;
   logic               ncio_mondo_ack;
   logic [AGTID_W-1:0] ncio_mondo_agnt_id;
   logic [CPUID_W-1:0] ncio_mondo_cpu_id;
   logic               mout_mondo_pop;
   logic               mout_int_req;
   logic               aok_int_gnt;
   logic               jbi_stall;
   logic               mout_int_vld;
   logic               mout_int_type;
   logic [AGTID_W-1:0] mout_int_agnt_id;
   logic [CPUID_W-1:0] mout_int_cpu_id;
   logic [CNT_W-1:0]   mout_ack_cnt;
   logic [CNT_W-1:0]   mout_nack_cnt;

   // Reply engine side
   modport master (
      input  ncio_mondo_req, ncio_mondo_ack, ncio_mondo_agnt_id, ncio_mondo_cpu_id,
      input  aok_int_gnt, jbi_stall,
      output mout_mondo_pop, mout_int_req, mout_int_vld, mout_int_type,
      output mout_int_agnt_id, mout_int_cpu_id, mout_ack_cnt, mout_nack_cnt
   );

   // Queue / arbiter / consumer side
   modport slave (
      output ncio_mondo_req, ncio_mondo_ack, ncio_mondo_agnt_id, ncio_mondo_cpu_id,
      output aok_int_gnt, jbi_stall,
      input  mout_mondo_pop, mout_int_req, mout_int_vld, mout_int_type,
      input  mout_int_agnt_id, mout_int_cpu_id, mout_ack_cnt, mout_nack_cnt
   );

endinterface
`default_nettype wire

// File: rtl/jbi_mout_mondo_reply_sat_cnt.sv
`default_nettype none
// ============================================================================
// jbi_sat_cnt : up-counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ============================================================================
module jbi_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/jbi_mout_mondo_reply.sv
`default_nettype none
// ============================================================================
// jbi_mout_mondo_reply : pops mondo ack/nack entries, arbitrates for JBus and
//                        issues INT_ACK/INT_NACK payloads; keeps debug counts
// Rev 1.0
// ============================================================================
module jbi_mout_mondo_reply
   import jbi_mout_mondo_reply_pkg::*;
#(
   parameter int AGTID_W    = c_agtid_w,
   parameter int CPUID_W    = c_cpuid_w,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_l,
   jbi_mout_mondo_reply_if.master bus
);

   localparam logic [2:0] c_gap_load = 3'(GAP_CYCLES);
   localparam logic       c_has_gap  = (GAP_CYCLES != 0);

   reply_state_t       r_state;
   reply_state_t       w_next_state;
   logic [2:0]         r_gap_cnt;
   logic               r_type;
   logic [AGTID_W-1:0] r_agnt_id;
   logic [CPUID_W-1:0] r_cpu_id;
   logic               w_grant;
   logic               w_inc_ack;
   logic               w_inc_nack;

   // Grant is only meaningful while our request is up
   assign w_grant = (r_state == ST_REQ) && bus.aok_int_gnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.ncio_mondo_req && !bus.jbi_stall) begin
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.aok_int_gnt) begin
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_next_state = c_has_gap ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (r_gap_cnt <= 3'd1) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Head is captured in the grant cycle, before the pop advances the queue
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_type    <= 1'b0;
         r_agnt_id <= '0;
         r_cpu_id  <= '0;
      end else if (w_grant) begin
         r_type    <= bus.ncio_mondo_ack;
         r_agnt_id <= bus.ncio_mondo_agnt_id;
         r_cpu_id  <= bus.ncio_mondo_cpu_id;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_gap_cnt <= 3'd0;
      end else if (r_state == ST_ISSUE) begin
         r_gap_cnt <= c_gap_load;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != 3'd0)) begin
         r_gap_cnt <= r_gap_cnt - 3'd1;
      end
   end

   assign w_inc_ack  = (r_state == ST_ISSUE) && (r_type == c_int_ack);
   assign w_inc_nack = (r_state == ST_ISSUE) && (r_type == c_int_nack);

   jbi_sat_cnt #(.WIDTH(CNT_W)) u_ack_cnt (
      .clk   (clk),
      .rst_l (rst_l),
      .inc   (w_inc_ack),
      .cnt   (bus.mout_ack_cnt)
   );

   jbi_sat_cnt #(.WIDTH(CNT_W)) u_nack_cnt (
      .clk   (clk),
      .rst_l (rst_l),
      .inc   (w_inc_nack),
      .cnt   (bus.mout_nack_cnt)
   );

   assign bus.mout_int_req     = (r_state == ST_REQ);
   assign bus.mout_mondo_pop   = w_grant;
   assign bus.mout_int_vld     = (r_state == ST_ISSUE);
   assign bus.mout_int_type    = r_type;
   assign bus.mout_int_agnt_id = r_agnt_id;
   assign bus.mout_int_cpu_id  = r_cpu_id;

   // Only this block pops, so the head must stay valid while we request
   a_req_held: assert property (@(posedge clk) disable iff (!rst_l)
                                (r_state == ST_REQ) |-> bus.ncio_mondo_req)
      else $error("ncio_mondo_req dropped while reply request outstanding");

endmodule
`default_nettype wire

// File: tb/tb_jbi_mout_mondo_reply.sv
`default_nettype none
// ============================================================================
// tb_jbi_mout_mondo_reply : directed self-checking bench for the mondo reply path
// Rev 1.0
// ============================================================================
module tb_jbi_mout_mondo_reply;

   typedef struct packed {
      logic       ack;
      logic [4:0] agnt;
      logic [4:0] cpu;
   } ent_t;

   logic clk;
   logic rst_l;
   int   n_total;
   int   n_pass;
   int   pop_cnt;
   int   vld_cnt;
   logic pop_seen;
   ent_t q[$];

   jbi_mout_mondo_reply_if #(.AGTID_W(5), .CPUID_W(5), .CNT_W(4)) bus ();

   jbi_mout_mondo_reply #(
      .AGTID_W    (5),
      .CPUID_W    (5),
      .GAP_CYCLES (1),
      .CNT_W      (4)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_head();
      bus.ncio_mondo_req = (q.size() != 0);
      if (q.size() != 0) begin
         bus.ncio_mondo_ack     = q[0].ack;
         bus.ncio_mondo_agnt_id = q[0].agnt;
         bus.ncio_mondo_cpu_id  = q[0].cpu;
      end else begin
         bus.ncio_mondo_ack     = 1'b0;
         bus.ncio_mondo_agnt_id = 5'h00;
         bus.ncio_mondo_cpu_id  = 5'h00;
      end
   endtask

   // Advance one clock; a pop seen before the edge retires the queue head
   task automatic tick();
      #1;
      pop_seen = bus.mout_mondo_pop;
      if (bus.mout_int_vld) vld_cnt++;
      @(negedge clk);
      if (pop_seen) begin
         pop_cnt++;
         if (q.size() != 0) void'(q.pop_front());
      end
      drive_head();
      #1;
   endtask

   initial begin
      n_total = 0; n_pass = 0; pop_cnt = 0; vld_cnt = 0; pop_seen = 1'b0;
      rst_l = 1'b0;
      bus.aok_int_gnt = 1'b0;
      bus.jbi_stall   = 1'b0;
      drive_head();
      repeat (3) @(negedge clk);
      #1;
      check("rst_req",  32'(bus.mout_int_req), 32'h0);
      check("rst_pop",  32'(bus.mout_mondo_pop), 32'h0);
      check("rst_vld",  32'(bus.mout_int_vld), 32'h0);
      check("rst_type", 32'(bus.mout_int_type), 32'h0);
      check("rst_agnt", 32'(bus.mout_int_agnt_id), 32'h0);
      check("rst_cpu",  32'(bus.mout_int_cpu_id), 32'h0);
      check("rst_ack",  32'(bus.mout_ack_cnt), 32'h0);
      check("rst_nack", 32'(bus.mout_nack_cnt), 32'h0);
      @(negedge clk);
      rst_l = 1'b1;
      #1;

      // Single ack, granted on the first REQ cycle
      q.push_back('{1'b1, 5'h03, 5'h11});
      drive_head();
      tick();
      check("t1_req", 32'(bus.mout_int_req), 32'h1);
      check("t1_pop_nognt", 32'(bus.mout_mondo_pop), 32'h0);
      bus.aok_int_gnt = 1'b1;
      #1;
      check("t1_pop", 32'(bus.mout_mondo_pop), 32'h1);
      tick();
      bus.aok_int_gnt = 1'b0;
      check("t1_vld",  32'(bus.mout_int_vld), 32'h1);
      check("t1_type", 32'(bus.mout_int_type), 32'h1);
      check("t1_agnt", 32'(bus.mout_int_agnt_id), 32'h03);
      check("t1_cpu",  32'(bus.mout_int_cpu_id), 32'h11);
      check("t1_req_off", 32'(bus.mout_int_req), 32'h0);
      tick();
      check("t1_ackcnt", 32'(bus.mout_ack_cnt), 32'h1);
      check("t1_vld_off", 32'(bus.mout_int_vld), 32'h0);
      check("t1_hold_agnt", 32'(bus.mout_int_agnt_id), 32'h03);
      tick();

      // Nack with grant withheld for 4 REQ cycles
      q.push_back('{1'b0, 5'h1A, 5'h07});
      drive_head();
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t2_req_wait", 32'(bus.mout_int_req), 32'h1);
         check("t2_pop_wait", 32'(bus.mout_mondo_pop), 32'h0);
         tick();
      end
      check("t2_req_5th", 32'(bus.mout_int_req), 32'h1);
      bus.aok_int_gnt = 1'b1;
      #1;
      check("t2_pop", 32'(bus.mout_mondo_pop), 32'h1);
      tick();
      bus.aok_int_gnt = 1'b0;
      check("t2_vld",  32'(bus.mout_int_vld), 32'h1);
      check("t2_type", 32'(bus.mout_int_type), 32'h0);
      check("t2_agnt", 32'(bus.mout_int_agnt_id), 32'h1A);
      check("t2_cpu",  32'(bus.mout_int_cpu_id), 32'h07);
      tick();
      check("t2_nackcnt", 32'(bus.mout_nack_cnt), 32'h1);
      check("t2_ackcnt",  32'(bus.mout_ack_cnt), 32'h1);
      tick();

      // Stall blocks a new request but not one already raised
      bus.jbi_stall = 1'b1;
      q.push_back('{1'b1, 5'h04, 5'h05});
      drive_head();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_stall_noreq", 32'(bus.mout_int_req), 32'h0);
      end
      bus.jbi_stall = 1'b0;
      tick();
      check("t3_req", 32'(bus.mout_int_req), 32'h1);
      bus.jbi_stall = 1'b1;
      tick();
      check("t3_req_held", 32'(bus.mout_int_req), 32'h1);
      bus.aok_int_gnt = 1'b1;
      #1;
      check("t3_pop", 32'(bus.mout_mondo_pop), 32'h1);
      tick();
      bus.aok_int_gnt = 1'b0;
      bus.jbi_stall   = 1'b0;
      check("t3_vld",  32'(bus.mout_int_vld), 32'h1);
      check("t3_agnt", 32'(bus.mout_int_agnt_id), 32'h04);
      tick();
      check("t3_ackcnt", 32'(bus.mout_ack_cnt), 32'h2);
      tick();

      // Back-to-back: four entries, grant always high, one reply every 4 cycles
      q.push_back('{1'b1, 5'h08, 5'h01});
      q.push_back('{1'b0, 5'h09, 5'h02});
      q.push_back('{1'b1, 5'h0A, 5'h03});
      q.push_back('{1'b1, 5'h0B, 5'h04});
      drive_head();
      bus.aok_int_gnt = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("t4_vld", 32'(bus.mout_int_vld), ((k % 4 == 2) && (k <= 14)) ? 32'h1 : 32'h0);
         check("t4_pop", 32'(bus.mout_mondo_pop), ((k % 4 == 1) && (k <= 13)) ? 32'h1 : 32'h0);
         if ((k % 4 == 2) && (k <= 14))
            check("t4_agnt", 32'(bus.mout_int_agnt_id), 32'(8 + k / 4));
      end
      bus.aok_int_gnt = 1'b0;
      check("t4_qempty",  32'(q.size()), 32'h0);
      check("t4_ackcnt",  32'(bus.mout_ack_cnt), 32'h5);
      check("t4_nackcnt", 32'(bus.mout_nack_cnt), 32'h2);
      check("t4_pops",    32'(pop_cnt), 32'd7);

      // Reset while requesting: entry must survive and be served once
      q.push_back('{1'b0, 5'h15, 5'h0C});
      drive_head();
      tick();
      check("t5_req", 32'(bus.mout_int_req), 32'h1);
      rst_l = 1'b0;
      #1;
      check("t5_rst_req",  32'(bus.mout_int_req), 32'h0);
      check("t5_rst_pop",  32'(bus.mout_mondo_pop), 32'h0);
      check("t5_rst_vld",  32'(bus.mout_int_vld), 32'h0);
      check("t5_rst_agnt", 32'(bus.mout_int_agnt_id), 32'h0);
      check("t5_rst_ack",  32'(bus.mout_ack_cnt), 32'h0);
      check("t5_rst_nack", 32'(bus.mout_nack_cnt), 32'h0);
      tick();
      tick();
      rst_l = 1'b1;
      check("t5_qkept", 32'(q.size()), 32'h1);
      tick();
      check("t5_req2", 32'(bus.mout_int_req), 32'h1);
      bus.aok_int_gnt = 1'b1;
      #1;
      check("t5_pop", 32'(bus.mout_mondo_pop), 32'h1);
      tick();
      bus.aok_int_gnt = 1'b0;
      check("t5_vld",  32'(bus.mout_int_vld), 32'h1);
      check("t5_type", 32'(bus.mout_int_type), 32'h0);
      check("t5_agnt", 32'(bus.mout_int_agnt_id), 32'h15);
      check("t5_cpu",  32'(bus.mout_int_cpu_id), 32'h0C);
      tick();
      check("t5_nackcnt", 32'(bus.mout_nack_cnt), 32'h1);
      tick();
      check("t5_pops", 32'(pop_cnt), 32'd8);

      // Saturation: 17 acks into a 4-bit counter
      for (int i = 0; i < 17; i++) q.push_back('{1'b1, 5'h1F, 5'(i)});
      drive_head();
      bus.aok_int_gnt = 1'b1;
      repeat (70) tick();
      bus.aok_int_gnt = 1'b0;
      check("t6_qempty",  32'(q.size()), 32'h0);
      check("t6_ackcnt",  32'(bus.mout_ack_cnt), 32'hF);
      check("t6_nackcnt", 32'(bus.mout_nack_cnt), 32'h1);
      check("t6_pops",    32'(pop_cnt), 32'd25);
      check("t6_vlds",    32'(vld_cnt), 32'd25);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
